// File: rtl/washer_pkg.sv
// Shared encodings for the washer plant model: mode values and err bit positions.
package washer_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE  = 3'd0,
    MODE_FILL  = 3'd1,
    MODE_WASH  = 3'd2,
    MODE_DRAIN = 3'd3,
    MODE_SPIN  = 3'd4,
    MODE_FAULT = 3'd5
  } mode_e;

  // err vector layout: {door_fill, conflict, wet_spin, dry_run, overfill}
  localparam int ERR_OVERFILL  = 0;
  localparam int ERR_DRY_RUN   = 1;
  localparam int ERR_WET_SPIN  = 2;
  localparam int ERR_CONFLICT  = 3;
  localparam int ERR_DOOR_FILL = 4;
  localparam int ERR_W         = 5;

endpackage

// File: rtl/plant_tick.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
// The tick is decoded from the counter, so the first plant update lands on
// the TICK_DIV-th edge after reset release.
module plant_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CNT_LAST);

  // wrap counter, restarts from zero on reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/washer_plant.sv
// Behavioural washing-machine plant: drum level, laundry moisture, door
// interlock, sticky fault flags and a registered mode indicator.
module washer_plant
  import washer_pkg::*;
#(
  parameter int LEVEL_MAX = 8,
  parameter int WET_MAX   = 6,
  parameter int TICK_DIV  = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           water_fill,
  input  logic                           motor_wash,
  input  logic                           motor_spin,
  input  logic                           drain,
  input  logic                           door_btn,
  input  logic                           err_clr,
  output logic                           water_full,
  output logic                           drained,
  output logic                           dry_sensor,
  output logic                           door_open,
  output logic [$clog2(LEVEL_MAX+1)-1:0] level,
  output logic [2:0]                     mode,
  output logic [4:0]                     err
);

  localparam int LW = $clog2(LEVEL_MAX + 1);
  localparam int MW = $clog2(WET_MAX + 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(LEVEL_MAX);
  localparam logic [MW-1:0] WET_FULL = MW'(WET_MAX);

  logic          tick;
  logic [MW-1:0] moisture;
  logic [ERR_W-1:0] err_cond;
  mode_e         mode_q, mode_d;

  plant_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  // status decoded straight from the registers, no extra latency
  assign water_full = (level == LVL_FULL);
  assign drained    = (level == '0);
  assign dry_sensor = (moisture == '0);
  assign mode       = mode_q;

  // drum level: fill or drain one unit per tick, opposing commands cancel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level <= '0;
    end else if (tick) begin
      if (water_fill && !drain && !door_open && level != LVL_FULL)
        level <= level + 1'b1;
      else if (drain && !water_fill && level != '0)
        level <= level - 1'b1;
    end
  end

  // moisture: soaked whenever water is present, spun down only when empty
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      moisture <= '0;
    end else if (tick) begin
      if (level != '0)
        moisture <= WET_FULL;
      else if (motor_spin && moisture != '0)
        moisture <= moisture - 1'b1;
    end
  end

  // door: closing is always allowed, opening only on an empty idle drum
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      door_open <= 1'b0;
    end else if (door_btn) begin
      if (door_open)
        door_open <= 1'b0;
      else if (level == '0 && !water_fill && !motor_wash && !motor_spin && !drain)
        door_open <= 1'b1;
    end
  end

  // fault conditions sampled every clock, independent of the tick
  always_comb begin
    err_cond                = '0;
    err_cond[ERR_OVERFILL]  = water_fill && (level == LVL_FULL);
    err_cond[ERR_DRY_RUN]   = motor_wash && (level == '0);
    err_cond[ERR_WET_SPIN]  = motor_spin && (level != '0);
    err_cond[ERR_CONFLICT]  = water_fill && drain;
    err_cond[ERR_DOOR_FILL] = water_fill && door_open;
  end

  // sticky flags; a live condition overrides a simultaneous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        err <= '0;
    else if (err_clr) err <= err_cond;
    else              err <= err | err_cond;
  end

  // mode state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) mode_q <= MODE_IDLE;
    else       mode_q <= mode_d;
  end

  // mode next-state: fault dominates, then command priority
  always_comb begin
    mode_d = MODE_IDLE;
    if (err != '0)       mode_d = MODE_FAULT;
    else if (water_fill) mode_d = MODE_FILL;
    else if (drain)      mode_d = MODE_DRAIN;
    else if (motor_spin) mode_d = MODE_SPIN;
    else if (motor_wash) mode_d = MODE_WASH;
  end

endmodule

// File: tb/tb_washer_plant.sv
// Directed bench for washer_plant with hand-computed expectations.
module tb_washer_plant;

  logic       clk, rstn;
  logic       water_fill, motor_wash, motor_spin, drain, door_btn, err_clr;
  logic       water_full, drained, dry_sensor, door_open;
  logic [3:0] level;
  logic [2:0] mode;
  logic [4:0] err;

  int errors = 0;
  int checks = 0;

  washer_plant #(.LEVEL_MAX(8), .WET_MAX(6), .TICK_DIV(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .water_fill (water_fill),
    .motor_wash (motor_wash),
    .motor_spin (motor_spin),
    .drain      (drain),
    .door_btn   (door_btn),
    .err_clr    (err_clr),
    .water_full (water_full),
    .drained    (drained),
    .dry_sensor (dry_sensor),
    .door_open  (door_open),
    .level      (level),
    .mode       (mode),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; water_fill = 0; motor_wash = 0; motor_spin = 0;
    drain = 0; door_btn = 0; err_clr = 0;
    #12;
    checks++;
    if ({level, drained, dry_sensor, water_full, door_open, err, mode} !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: lvl=%0d drn=%b dry=%b full=%b door=%b err=%b mode=%0d, want 0 1 1 0 0 00000 0",
               level, drained, dry_sensor, water_full, door_open, err, mode);
    end
  endtask

  task automatic test_fill;
    @(posedge clk); #1;
    rstn = 1'b1; water_fill = 1'b1;
    step(31);
    checks++;
    if (level !== 4'd7 || water_full !== 1'b0) begin
      errors++; $display("FAIL fill_c31: level=%0d full=%b, want 7 0", level, water_full);
    end
    step(1);
    checks++;
    if (level !== 4'd8 || water_full !== 1'b1 || err !== 5'd0 || mode !== 3'd1) begin
      errors++; $display("FAIL fill_c32: level=%0d full=%b err=%b mode=%0d, want 8 1 00000 1", level, water_full, err, mode);
    end
    water_fill = 1'b0;
  endtask

  task automatic test_drain;
    drain = 1'b1;
    step(31);
    checks++;
    if (level !== 4'd1 || drained !== 1'b0) begin
      errors++; $display("FAIL drain_c31: level=%0d drained=%b, want 1 0", level, drained);
    end
    step(1);
    checks++;
    if (level !== 4'd0 || drained !== 1'b1 || mode !== 3'd3) begin
      errors++; $display("FAIL drain_c32: level=%0d drained=%b mode=%0d, want 0 1 3", level, drained, mode);
    end
    step(4);
    checks++;
    if (level !== 4'd0 || err !== 5'd0) begin
      errors++; $display("FAIL drain_underflow: level=%0d err=%b, want 0 00000", level, err);
    end
  endtask

  task automatic test_spin;
    drain = 1'b0; motor_spin = 1'b1;
    checks++;
    if (dry_sensor !== 1'b0) begin
      errors++; $display("FAIL spin_wet_start: dry=%b, want 0", dry_sensor);
    end
    step(23);
    checks++;
    if (dry_sensor !== 1'b0) begin
      errors++; $display("FAIL spin_c23: dry=%b, want 0", dry_sensor);
    end
    step(1);
    checks++;
    if (dry_sensor !== 1'b1 || err[2] !== 1'b0 || mode !== 3'd4) begin
      errors++; $display("FAIL spin_c24: dry=%b wet_spin=%b mode=%0d, want 1 0 4", dry_sensor, err[2], mode);
    end
    motor_spin = 1'b0;
  endtask

  task automatic test_dry_run;
    motor_wash = 1'b1;
    step(1);
    checks++;
    if (err !== 5'b00010) begin
      errors++; $display("FAIL dry_run_flag: err=%b, want 00010", err);
    end
    motor_wash = 1'b0;
    step(1);
    checks++;
    if (mode !== 3'd5) begin
      errors++; $display("FAIL dry_run_fault: mode=%0d, want 5", mode);
    end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    checks++;
    if (err !== 5'd0) begin
      errors++; $display("FAIL dry_run_clear: err=%b, want 00000", err);
    end
  endtask

  task automatic test_conflict;
    int n;
    water_fill = 1'b1;
    n = 0;
    while (level != 4'd3 && n < 100) begin step(1); n++; end
    checks++;
    if (level !== 4'd3) begin
      errors++; $display("FAIL conflict_setup: level=%0d, want 3", level);
    end
    drain = 1'b1;
    step(8);
    checks++;
    if (level !== 4'd3 || err !== 5'b01000 || mode !== 3'd5) begin
      errors++; $display("FAIL conflict_hold: level=%0d err=%b mode=%0d, want 3 01000 5", level, err, mode);
    end
    water_fill = 1'b0; drain = 1'b0; err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    checks++;
    if (err !== 5'd0 || mode !== 3'd5) begin
      errors++; $display("FAIL conflict_clr: err=%b mode=%0d, want 00000 5", err, mode);
    end
    step(1);
    checks++;
    if (mode !== 3'd0) begin
      errors++; $display("FAIL conflict_exit: mode=%0d, want 0", mode);
    end
  endtask

  task automatic test_clr_vs_cond;
    water_fill = 1'b1; drain = 1'b1;
    step(1);
    err_clr = 1'b1;
    step(1);
    checks++;
    if (err[3] !== 1'b1) begin
      errors++; $display("FAIL clr_priority: conflict=%b, want 1", err[3]);
    end
    water_fill = 1'b0; drain = 1'b0;
    step(1);
    err_clr = 1'b0;
    checks++;
    if (err !== 5'd0) begin
      errors++; $display("FAIL clr_after: err=%b, want 00000", err);
    end
    step(1);
  endtask

  task automatic test_door;
    int n;
    door_btn = 1'b1;
    step(1);
    door_btn = 1'b0;
    checks++;
    if (door_open !== 1'b0) begin
      errors++; $display("FAIL door_locked: door=%b level=%0d, want 0", door_open, level);
    end
    drain = 1'b1;
    n = 0;
    while (level != 4'd0 && n < 100) begin step(1); n++; end
    checks++;
    if (level !== 4'd0) begin
      errors++; $display("FAIL door_drain_timeout: level=%0d, want 0", level);
    end
    drain = 1'b0; door_btn = 1'b1;
    step(1);
    door_btn = 1'b0;
    checks++;
    if (door_open !== 1'b1) begin
      errors++; $display("FAIL door_open: door=%b, want 1", door_open);
    end
    water_fill = 1'b1;
    step(8);
    checks++;
    if (level !== 4'd0 || err !== 5'b10000) begin
      errors++; $display("FAIL door_fill: level=%0d err=%b, want 0 10000", level, err);
    end
    water_fill = 1'b0; err_clr = 1'b1; door_btn = 1'b1;
    step(1);
    err_clr = 1'b0; door_btn = 1'b0;
    checks++;
    if (door_open !== 1'b0 || err !== 5'd0) begin
      errors++; $display("FAIL door_close: door=%b err=%b, want 0 00000", door_open, err);
    end
  endtask

  task automatic test_mid_reset;
    int n;
    water_fill = 1'b1;
    n = 0;
    while (level != 4'd5 && n < 100) begin step(1); n++; end
    checks++;
    if (level !== 4'd5) begin
      errors++; $display("FAIL midrst_setup: level=%0d, want 5", level);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (level !== 4'd0 || drained !== 1'b1 || mode !== 3'd0 || dry_sensor !== 1'b1) begin
      errors++; $display("FAIL midrst_async: level=%0d drained=%b mode=%0d dry=%b, want 0 1 0 1", level, drained, mode, dry_sensor);
    end
    water_fill = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1; water_fill = 1'b1;
    step(3);
    checks++;
    if (level !== 4'd0) begin
      errors++; $display("FAIL midrst_c3: level=%0d, want 0", level);
    end
    step(1);
    checks++;
    if (level !== 4'd1) begin
      errors++; $display("FAIL midrst_first_tick: level=%0d, want 1", level);
    end
    water_fill = 1'b0;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_spin;
    test_dry_run;
    test_conflict;
    test_clr_vs_cond;
    test_door;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/washer_plant.md
WASHER_PLANT -- requirements
Module: washer_plant

Interface
REQ-001 Parameters SHALL be, one per line:
- LEVEL_MAX, 8, drum level units at full
- WET_MAX, 6, laundry moisture units when soaked
- TICK_DIV, 4, clk cycles per plant tick (>=2)

REQ-002 Ports SHALL be as follows (name, direction, width, meaning), clock and reset first:
- clk, in, 1, clock
- rstn, in, 1, asynchronous active-low reset
- water_fill, in, 1, fill valve command
- motor_wash, in, 1, wash motor command
- motor_spin, in, 1, spin motor command
- drain, in, 1, drain pump command
- door_btn, in, 1, one-cycle door toggle request
- err_clr, in, 1, clear sticky errors
- water_full, out, 1, level==LEVEL_MAX
- drained, out, 1, level==0
- dry_sensor, out, 1, moisture==0
- door_open, out, 1, door state
- level, out, $clog2(LEVEL_MAX+1), drum level
- mode, out, 3, plant mode
- err, out, 5, sticky flags {door_fill, conflict, wet_spin, dry_run, overfill}

Function
REQ-003 Internal tick SHALL pulse for one clk every TICK_DIV cycles, free-running, first pulse TICK_DIV cycles after reset release.
REQ-004 On tick: water_fill & !drain & !door_open & level<LEVEL_MAX SHALL increment level by 1.
REQ-005 On tick: drain & !water_fill & level>0 SHALL decrement level by 1.
REQ-006 water_fill & drain together SHALL leave level unchanged; level SHALL saturate at 0 and LEVEL_MAX, never wrap.
REQ-007 Moisture SHALL load WET_MAX on any tick where level>0.
REQ-008 On a tick where level==0 & motor_spin, moisture SHALL decrement by 1, saturating at 0.
REQ-009 water_full, drained and dry_sensor SHALL be decoded from the level/moisture registers, so they are valid in the same cycle the register updates.
REQ-010 door_btn while door_open SHALL close the door next cycle.
REQ-011 door_btn while closed SHALL open the door next cycle only if level==0 and all four commands are 0; otherwise it SHALL be ignored.
REQ-012 Error flags SHALL be evaluated every clk, not every tick, and set sticky:
- overfill: water_fill & level==LEVEL_MAX
- dry_run: motor_wash & level==0
- wet_spin: motor_spin & level>0
- conflict: water_fill & drain
- door_fill: water_fill & door_open
REQ-013 err_clr SHALL zero all flags; a condition true in the same cycle SHALL win (flag stays set).
REQ-014 mode SHALL be a registered FSM, updated every clk:
- FAULT (5) while err!=0
- else, by priority: FILL (1) on water_fill, DRAIN (3) on drain, SPIN (4) on motor_spin, WASH (2) on motor_wash
- else IDLE (0)
REQ-015 FAULT SHALL exit to the priority-selected mode the cycle after err becomes 0.

Reset
REQ-016 On rstn low, asynchronously:
- level=0, moisture=0, tick counter=0
- door_open=0, err=0, mode=IDLE
- resulting outputs: drained=1, dry_sensor=1, water_full=0
REQ-017 Reset mid-operation SHALL abandon the current level and moisture without any ramp.

Structure
REQ-018 Mode encodings and err bit indices SHALL live in shared package washer_pkg, for use by washer_ctrl benches.
REQ-019 The tick prescaler SHALL be one sub-module, plant_tick (parameter TICK_DIV, output tick); all other logic SHALL be in washer_plant.

Verification
REQ-020 Fill from empty: water_fill held from reset release -> level reaches 8 and water_full=1 at cycle 32; err stays 0.
REQ-021 Drain from full: drain held from level 8 -> drained=1 after 8 ticks (32 cycles); level never underflows while drain stays high.
REQ-022 Spin dry: after a fill, drain to 0, then motor_spin held -> dry_sensor=1 after 6 ticks (24 cycles); err.wet_spin=0.
REQ-023 Conflict: water_fill=drain=1 at level 3 for 8 cycles -> level stays 3, err.conflict=1, mode=FAULT; err_clr pulse -> err=0, mode returns the cycle after err=0.
REQ-024 Door interlock at level 3:
- door_btn -> door_open stays 0
- at level 0 with commands idle: door_btn -> door_open=1 next cycle
- then water_fill for 8 cycles -> level stays 0, err.door_fill=1
REQ-025 Reset mid-fill at level 5 -> level=0, drained=1, mode=IDLE immediately; the first tick occurs TICK_DIV cycles after release.
